adder_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 10-bit final_adder (CLA) among several requesters in the Wallace 5x5 multiplier datapath. It accepts one add request at a time over a valid/ready handshake and registers the operands. It drives the shared adder, captures the sum and carry, and returns them tagged with the requester id over a second valid/ready handshake.

---
 rtl/adder_share_arbiter.sv | 150 +++++++++++++++
 tb/tb_adder_share_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter.sv
// Round-robin front end that time-shares one external WIDTH-bit adder; results return tagged with the requester id.
// Two clock edges from accept to rsp_valid; one add per 2 cycles at best. A stalled response blocks all new grants.
module adder_share_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 10,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_cin,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    output logic                     add_cin,
    input  logic [WIDTH-1:0]         add_sum,
    input  logic                     add_cout,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_cout,
    output logic                     busy
);

    typedef enum logic [1:0] {IDLE, ADD, RESP} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [WIDTH-1:0]  op_a_q, op_a_d;
    logic [WIDTH-1:0]  op_b_q, op_b_d;
    logic              op_cin_q, op_cin_d;
    logic [ID_W-1:0]   op_id_q, op_id_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]  rsp_sum_q, rsp_sum_d;
    logic              rsp_cout_q, rsp_cout_d;

    logic              arb_en;
    logic              any_vld;
    logic              accept;
    logic [ID_W-1:0]   g;
    logic [ID_W-1:0]   cand;
    int                k;

    // Rotating priority search starting at ptr_q; depends only on valids.
    always_comb begin
        any_vld = 1'b0;
        g       = '0;
        cand    = '0;
        k       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = int'(ptr_q) + i;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            cand = ID_W'(k);
            if (!any_vld && req_valid[cand]) begin
                any_vld = 1'b1;
                g       = cand;
            end
        end
    end

    assign arb_en = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
    // rst_n gate keeps grants off while reset is held, even though state already reads IDLE.
    assign accept = arb_en && any_vld && rst_n;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[g] = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_cin_d    = op_cin_q;
        op_id_d     = op_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;

        if (accept) begin
            op_a_d   = req_a[g*WIDTH +: WIDTH];
            op_b_d   = req_b[g*WIDTH +: WIDTH];
            op_cin_d = req_cin[g];
            op_id_d  = g;
            ptr_d    = (g == ID_W'(NUM_REQ - 1)) ? '0 : g + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (accept) state_d = ADD;
            end
            ADD: begin
                rsp_sum_d   = add_sum;
                rsp_cout_d  = add_cout;
                rsp_id_d    = op_id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = accept ? ADD : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_cin_q    <= 1'b0;
            op_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_cin_q    <= op_cin_d;
            op_id_q     <= op_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
        end
    end

    assign add_a     = op_a_q;
    assign add_b     = op_b_q;
    assign add_cin   = op_cin_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Scoreboard bench for adder_share_arbiter: grants push expected results, a monitor pops them on each response handshake.
module tb_adder_share_arbiter;

    localparam int N = 4;
    localparam int W = 10;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_cin;
    logic [W-1:0]   add_a, add_b, add_sum;
    logic           add_cin, add_cout;
    logic           rsp_valid;
    logic           rsp_ready = 1'b1;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_sum;
    logic           rsp_cout;
    logic           busy;

    logic [W-1:0]   a_tab [N];
    logic [W-1:0]   b_tab [N];
    logic           cin_tab [N];
    logic [W-1:0]   es_tab [N];
    logic           ec_tab [N];

    typedef struct {
        logic [1:0]   id;
        logic [W-1:0] sum;
        logic         cout;
    } rsp_t;

    rsp_t         exp_q [$];
    int           grant_log [$];
    int           grant_cyc [$];
    logic [N-1:0] granted_last = '0;
    logic [N-1:0] gm;
    logic [N-1:0] oneshot = '1;
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Shared adder stand-in
    assign {add_cout, add_sum} = 11'(add_a) + 11'(add_b) + 11'(add_cin);

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = a_tab[i];
            req_b[i*W +: W] = b_tab[i];
            req_cin[i]      = cin_tab[i];
        end
    end

    adder_share_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .busy(busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Grant observer: every accepted request pushes its hand-computed result.
    always @(negedge clk) begin
        gm = '0;
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    gm[i] = 1'b1;
                    exp_q.push_back('{id: 2'(i), sum: es_tab[i], cout: ec_tab[i]});
                    grant_log.push_back(i);
                    grant_cyc.push_back(cyc);
                end
            end
        end
        granted_last = gm;
    end

    // Response monitor
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got id=%0d sum=%0d cout=%0d expected no response", rsp_id, rsp_sum, rsp_cout);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_sum", 32'(rsp_sum), 32'(e.sum));
                chk("rsp_cout", 32'(rsp_cout), 32'(e.cout));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        req_valid = req_valid & ~(granted_last & oneshot);
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                           input logic [W-1:0] es, input logic ec);
        a_tab[i] = a; b_tab[i] = b; cin_tab[i] = c; es_tab[i] = es; ec_tab[i] = ec;
    endtask

    task automatic wait_grants(input string nm, input int n, input int max);
        int t = 0;
        while (grant_log.size() < n && t < max) begin
            tick();
            t++;
        end
        chk({nm, "_grant_timeout"}, 32'(grant_log.size() >= n), 1);
    endtask

    task automatic wait_rsp(input string nm, input int max);
        int t = 0;
        while (!rsp_valid && t < max) begin
            tick();
            t++;
        end
        chk({nm, "_rsp_timeout"}, 32'(rsp_valid), 1);
    endtask

    task automatic drain(input string nm);
        repeat (6) tick();
        chk({nm, "_sb_empty"}, 32'(exp_q.size()), 0);
    endtask

    task automatic check_log(input string nm, input int idx, input int req);
        if (grant_log.size() > idx) chk(nm, 32'(grant_log[idx]), 32'(req));
        else chk({nm, "_missing"}, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < N; i++) set_req(i, '0, '0, 1'b0, '0, 1'b0);

        // 1: reset, with valids raised to confirm grants stay off while reset is held
        rst_n = 1'b0;
        req_valid = 4'b1111;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        repeat (3) tick();
        req_valid = '0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_add_a", 32'(add_a), 0);
        chk("idle_add_b", 32'(add_b), 0);
        chk("idle_add_cin", 32'(add_cin), 0);
        chk("idle_rsp_valid", 32'(rsp_valid), 0);
        chk("idle_rsp_id", 32'(rsp_id), 0);
        chk("idle_rsp_sum", 32'(rsp_sum), 0);
        chk("idle_rsp_cout", 32'(rsp_cout), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_req_ready", 32'(req_ready), 0);

        // 2: single request, 0x3FF + 1 = 0x400
        tick();
        set_req(0, 10'h3FF, 10'h001, 1'b0, 10'h000, 1'b1);
        req_valid = 4'b0001;
        @(negedge clk);
        chk("single_req_ready", 32'(req_ready), 32'h1);
        tick();
        @(negedge clk);
        chk("single_add_busy", 32'(busy), 1);
        chk("single_add_ready", 32'(req_ready), 0);
        chk("single_add_a", 32'(add_a), 32'h3FF);
        chk("single_add_b", 32'(add_b), 32'h001);
        chk("single_add_cin", 32'(add_cin), 0);
        chk("single_add_rspv", 32'(rsp_valid), 0);
        tick();
        @(negedge clk);
        chk("single_latency_rspv", 32'(rsp_valid), 1);
        drain("single");

        // 3: round robin from a fresh pointer
        rst_n = 1'b0;
        exp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < N; i++) set_req(i, 10'(i), 10'd100, 1'b0, 10'(100 + i), 1'b0);
        grant_log.delete();
        grant_cyc.delete();
        oneshot = '0;
        req_valid = 4'b1111;
        wait_grants("rr", 5, 30);
        req_valid = '0;
        oneshot = '1;
        for (int j = 0; j < 5; j++) check_log("rr_order", j, j % N);
        for (int j = 1; j < 5 && j < grant_cyc.size(); j++)
            chk("rr_spacing", 32'(grant_cyc[j] - grant_cyc[j-1]), 2);
        drain("rr");

        // 4: backpressure, 0x2AA + 0x155 + 1 = 0x400
        rsp_ready = 1'b0;
        set_req(1, 10'h2AA, 10'h155, 1'b1, 10'h000, 1'b1);
        set_req(2, 10'd5, 10'd6, 1'b0, 10'd11, 1'b0);
        grant_log.delete();
        req_valid = 4'b0110;
        wait_rsp("bp", 10);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 32'(rsp_valid), 1);
            chk("bp_rsp_sum", 32'(rsp_sum), 0);
            chk("bp_rsp_cout", 32'(rsp_cout), 1);
            chk("bp_rsp_id", 32'(rsp_id), 1);
            chk("bp_req_ready", 32'(req_ready), 0);
            tick();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_same_cycle_grant", 32'(req_ready), 32'h4);
        tick();
        @(negedge clk);
        chk("bp_rspv_gap", 32'(rsp_valid), 0);
        wait_rsp("bp2", 10);
        drain("bp");
        check_log("bp_order0", 0, 1);
        check_log("bp_order1", 1, 2);

        // 5: wrap-around with ptr=3; 0x3FF + 0x3FF + 1 = 0x7FF
        set_req(3, 10'h3FF, 10'h3FF, 1'b1, 10'h3FF, 1'b1);
        set_req(0, 10'd0, 10'd0, 1'b0, 10'd0, 1'b0);
        grant_log.delete();
        req_valid = 4'b1001;
        wait_grants("wrap", 2, 20);
        drain("wrap");
        check_log("wrap_order0", 0, 3);
        check_log("wrap_order1", 1, 0);
        // ptr should now be 1, so req1 beats req0
        set_req(1, 10'd12, 10'd34, 1'b1, 10'd47, 1'b0);
        set_req(0, 10'd200, 10'd300, 1'b0, 10'd500, 1'b0);
        grant_log.delete();
        req_valid = 4'b0011;
        wait_grants("ptr1", 2, 20);
        drain("ptr1");
        check_log("ptr1_order0", 0, 1);
        check_log("ptr1_order1", 1, 0);

        // 6: reset during ADD drops the operation
        set_req(2, 10'd7, 10'd8, 1'b0, 10'd15, 1'b0);
        req_valid = 4'b0100;
        tick();
        chk("midrst_in_add", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_rspv", 32'(rsp_valid), 0);
        chk("midrst_add_a", 32'(add_a), 0);
        chk("midrst_ready", 32'(req_ready), 0);
        exp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_rsp", 32'(rsp_valid), 0);
            tick();
        end
        // ptr back at 0, so req0 beats req3
        set_req(0, 10'd1, 10'd2, 1'b1, 10'd4, 1'b0);
        set_req(3, 10'h200, 10'h200, 1'b0, 10'h000, 1'b1);
        grant_log.delete();
        req_valid = 4'b1001;
        wait_grants("post", 2, 20);
        drain("post");
        check_log("post_order0", 0, 0);
        check_log("post_order1", 1, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
